// File: rtl/mult_div_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply/divide unit.
// EX drives the request side as master; the unit answers through the slave modport.
interface mult_div_if;
    logic        start;
    logic        flush;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        done;
    logic        busy;
    logic [63:0] result;

    modport master (
        output start, flush, funct, operand_1, operand_2,
        input  done, busy, result
    );

    modport slave (
        input  start, flush, funct, operand_1, operand_2,
        output done, busy, result
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 32 radix-2 steps on unsigned magnitudes,
// then a sign-fix cycle that registers {HI,LO} and pulses done.
module mult_div_unit #(
    parameter logic [5:0] FUNCT_MULT  = 6'h18,
    parameter logic [5:0] FUNCT_MULTU = 6'h19,
    parameter logic [5:0] FUNCT_DIV   = 6'h1a,
    parameter logic [5:0] FUNCT_DIVU  = 6'h1b
) (
    input logic       clk,
    input logic       rst_n,
    mult_div_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, SIGN, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  counter;
    logic [63:0] acc;
    logic [31:0] step_operand;
    logic [31:0] op1_raw;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic        done_q;
    logic [63:0] result_q;

    logic        valid_funct;
    logic        op_signed;
    logic        op_div;
    logic        accept;
    logic        in_neg_a;
    logic        in_neg_b;
    logic [31:0] mag_1;
    logic [31:0] mag_2;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;
    logic [63:0] final_result;

    assign valid_funct = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU) ||
                         (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
    assign op_signed   = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
    assign op_div      = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
    assign accept      = (state == IDLE) && bus.start && !bus.flush && valid_funct;
    assign in_neg_a    = op_signed && bus.operand_1[31];
    assign in_neg_b    = op_signed && bus.operand_2[31];
    assign mag_1       = in_neg_a ? -bus.operand_1 : bus.operand_1;
    assign mag_2       = in_neg_b ? -bus.operand_2 : bus.operand_2;

    // Shared accumulator: for mult the low half starts as the multiplier and the
    // partial product grows into the high half; for div it is the {rem, quot} shifter.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, step_operand} : 33'd0);
    assign mul_next  = {mul_sum, acc[31:1]};
    assign div_shift = acc[63:31];
    assign div_diff  = div_shift - {1'b0, step_operand};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0],  acc[30:0], 1'b1};

    assign quot_fixed   = (neg_a ^ neg_b) ? -acc[31:0] : acc[31:0];
    assign rem_fixed    = neg_a ? -acc[63:32] : acc[63:32];
    assign final_result = !is_div        ? ((neg_a ^ neg_b) ? -acc : acc) :
                          div_zero       ? {op1_raw, 32'hFFFF_FFFF} :
                                           {rem_fixed, quot_fixed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = BUSY;
                BUSY:    if (counter == 5'd31) state_next = SIGN;
                SIGN:    state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter      <= 5'd0;
            acc          <= 64'd0;
            step_operand <= 32'd0;
            op1_raw      <= 32'd0;
            is_div       <= 1'b0;
            neg_a        <= 1'b0;
            neg_b        <= 1'b0;
            div_zero     <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= 64'd0;
        end else begin
            if (accept) begin
                counter      <= 5'd0;
                acc          <= {32'd0, op_div ? mag_1 : mag_2};
                step_operand <= op_div ? mag_2 : mag_1;
                op1_raw      <= bus.operand_1;
                is_div       <= op_div;
                neg_a        <= in_neg_a;
                neg_b        <= in_neg_b;
                div_zero     <= (bus.operand_2 == 32'd0);
            end else if ((state == BUSY) && !bus.flush) begin
                counter <= counter + 5'd1;
                acc     <= is_div ? div_next : mul_next;
            end
            done_q <= (state == SIGN) && !bus.flush;
            if ((state == SIGN) && !bus.flush) begin
                result_q <= final_result;
            end
        end
    end

    assign bus.done   = done_q;
    assign bus.busy   = (state != IDLE);
    assign bus.result = result_q;

endmodule
